// File: rtl/pwl2real_pkg.sv
// Shared types and helpers for the pwl-to-real sampler.
// PWL2REAL_SLOPE_OUT_EN adds a slope field to every FIFO entry.
`timescale 1ns/1ps
package pwl2real_pkg;

  localparam int  DECIM_DEF      = 4;
  localparam int  FIFO_DEPTH_DEF = 4;
  localparam real TIME_UNIT_S    = 1.0e-9;

  typedef struct {
    real a;
    real b;
    real t0;
  } pwl_t;

  typedef struct {
    real val;
`ifdef PWL2REAL_SLOPE_OUT_EN
    real slope;
`endif
  } entry_t;

  function automatic real pwl_eval(input pwl_t p, input real t_s);
    return p.a + p.b * (t_s - p.t0);
  endfunction

  function automatic int unsigned ptr_inc(input int unsigned p, input int unsigned depth);
    return (p >= depth - 1) ? 0 : p + 1;
  endfunction

  // Closes a window: partial sums plus the sample taken at this edge.
  function automatic entry_t window_avg(input entry_t acc, input pwl_t p, input real t_s,
                                        input int decim);
    entry_t e;
    e.val = (acc.val + pwl_eval(p, t_s)) / real'(decim);
`ifdef PWL2REAL_SLOPE_OUT_EN
    e.slope = (acc.slope + p.b) / real'(decim);
`endif
    return e;
  endfunction

endpackage

// File: rtl/pwl2real_if.sv
// Sample/handshake bundle between the pwl source, the sampler and its consumer.
// PWL2REAL_SLOPE_OUT_EN adds o_out_slope.
`timescale 1ns/1ps
interface pwl2real_if;

  pwl2real_pkg::pwl_t i_in;
  logic               i_en;
  logic               i_out_ready;
  real                o_out;
  logic               o_out_valid;
  logic               o_ovf;
`ifdef PWL2REAL_SLOPE_OUT_EN
  real                o_out_slope;

  modport master (output i_in, i_en, i_out_ready,
                  input  o_out, o_out_valid, o_ovf, o_out_slope);
  modport slave  (input  i_in, i_en, i_out_ready,
                  output o_out, o_out_valid, o_ovf, o_out_slope);
`else
  modport master (output i_in, i_en, i_out_ready,
                  input  o_out, o_out_valid, o_ovf);
  modport slave  (input  i_in, i_en, i_out_ready,
                  output o_out, o_out_valid, o_ovf);
`endif

endinterface

// File: rtl/pwl2real_sampler_real_fifo.sv
// Sync FIFO of averaged entries; the closing sample is folded in at the push edge.
// Entry layout follows PWL2REAL_SLOPE_OUT_EN through entry_t.
`timescale 1ns/1ps
module real_fifo
  import pwl2real_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter int DECIM = DECIM_DEF
) (
  input  logic   i_clk,
  input  logic   i_rst,
  input  logic   i_push,
  input  logic   i_pop,
  input  entry_t i_acc,
  input  pwl_t   i_pwl,
  output entry_t o_head,
  output logic   o_empty,
  output logic   o_ovf
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  entry_t          r_mem [DEPTH];
  entry_t          r_head;
  logic [AW-1:0]   r_rd;
  logic [AW-1:0]   r_wr;
  logic [CW-1:0]   r_cnt;
  logic            r_ovf;

  logic            w_full;
  logic            w_do_pop;
  logic            w_do_push;
  logic            w_head_is_new;
  logic [AW-1:0]   w_rd_nxt;
  logic [CW-1:0]   w_left;

  assign o_empty   = (r_cnt == '0);
  assign w_full    = (r_cnt == CW'(DEPTH));
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!w_full || w_do_pop);
  assign w_rd_nxt  = w_do_pop ? AW'(ptr_inc(32'(r_rd), DEPTH)) : r_rd;
  assign w_left    = r_cnt - CW'(w_do_pop);
  // A word pushed into an (effectively) empty queue is the new head this edge.
  assign w_head_is_new = w_do_push && (w_left == '0);

  always_ff @(posedge i_clk) begin
    if (!i_rst && w_do_push)
      r_mem[r_wr] <= window_avg(i_acc, i_pwl, $realtime * TIME_UNIT_S, DECIM);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd       <= '0;
      r_wr       <= '0;
      r_cnt      <= '0;
      r_ovf      <= 1'b0;
      r_head.val <= 0.0;
`ifdef PWL2REAL_SLOPE_OUT_EN
      r_head.slope <= 0.0;
`endif
    end else begin
      r_rd  <= w_rd_nxt;
      r_cnt <= w_left + CW'(w_do_push);
      if (w_do_push)
        r_wr <= AW'(ptr_inc(32'(r_wr), DEPTH));
      if (i_push && !w_do_push)
        r_ovf <= 1'b1;
      if (w_head_is_new)
        r_head <= window_avg(i_acc, i_pwl, $realtime * TIME_UNIT_S, DECIM);
      else if (w_left != '0)
        r_head <= r_mem[w_rd_nxt];
    end
  end

  assign o_head = r_head;
  assign o_ovf  = r_ovf;

endmodule

// File: rtl/pwl2real_sampler.sv
// Clocked pwl-to-real sampler: decimating average into a valid/ready FIFO.
// PWL2REAL_SLOPE_OUT_EN also averages the pwl slope and exports it as o_out_slope.
`timescale 1ns/1ps
module pwl2real_sampler
  import pwl2real_pkg::*;
#(
  parameter int DECIM      = DECIM_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input logic        i_clk,
  input logic        i_rst,
  pwl2real_if.slave  bus
);

  localparam int NW = (DECIM > 1) ? $clog2(DECIM) : 1;

  logic [NW-1:0] r_cnt;
  entry_t        r_acc;
  logic          w_last;
  logic          w_push;
  logic          w_empty;
  logic          w_ovf;
  entry_t        w_head;

  assign w_last = (r_cnt == NW'(DECIM - 1));
  assign w_push = bus.i_en && w_last;

  // Partial sums exclude the closing sample; the FIFO adds it at the push edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt     <= '0;
      r_acc.val <= 0.0;
`ifdef PWL2REAL_SLOPE_OUT_EN
      r_acc.slope <= 0.0;
`endif
    end else if (bus.i_en) begin
      if (w_last) begin
        r_cnt     <= '0;
        r_acc.val <= 0.0;
`ifdef PWL2REAL_SLOPE_OUT_EN
        r_acc.slope <= 0.0;
`endif
      end else begin
        r_cnt     <= r_cnt + 1'b1;
        r_acc.val <= r_acc.val + pwl_eval(bus.i_in, $realtime * TIME_UNIT_S);
`ifdef PWL2REAL_SLOPE_OUT_EN
        r_acc.slope <= r_acc.slope + bus.i_in.b;
`endif
      end
    end
  end

  real_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DECIM (DECIM)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_pop   (bus.i_out_ready),
    .i_acc   (r_acc),
    .i_pwl   (bus.i_in),
    .o_head  (w_head),
    .o_empty (w_empty),
    .o_ovf   (w_ovf)
  );

  assign bus.o_out       = w_head.val;
  assign bus.o_out_valid = !w_empty;
  assign bus.o_ovf       = w_ovf;
`ifdef PWL2REAL_SLOPE_OUT_EN
  assign bus.o_out_slope = w_head.slope;
`endif

endmodule

// File: tb/tb_pwl2real_sampler.sv
// Bench for pwl2real_sampler: DECIM=4 and DECIM=1 instances against a queue-based model.
// Slope output is checked only when PWL2REAL_SLOPE_OUT_EN is defined.
`timescale 1ns/1ps
module tb_pwl2real_sampler;
  import pwl2real_pkg::*;

  localparam int  DEPTH = 4;
  localparam real TOL   = 1.0e-9;

  logic clk;
  logic rst;

  pwl2real_if bus4 ();
  pwl2real_if bus1 ();

  pwl2real_sampler #(.DECIM(4), .FIFO_DEPTH(DEPTH)) u_dut4 (
    .i_clk (clk), .i_rst (rst), .bus (bus4.slave));
  pwl2real_sampler #(.DECIM(1), .FIFO_DEPTH(DEPTH)) u_dut1 (
    .i_clk (clk), .i_rst (rst), .bus (bus1.slave));

  logic tb_en  [2];
  logic tb_rdy [2];
  pwl_t tb_in  [2];

  assign bus4.i_en        = tb_en[0];
  assign bus4.i_out_ready = tb_rdy[0];
  assign bus4.i_in        = tb_in[0];
  assign bus1.i_en        = tb_en[1];
  assign bus1.i_out_ready = tb_rdy[1];
  assign bus1.i_in        = tb_in[1];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: a window is a list of samples, the output queue a list of words.
  int   m_dec   [2];
  real  m_win   [2][$];
  real  m_wins  [2][$];
  real  m_q     [2][$];
  real  m_qs    [2][$];
  real  m_last  [2];
  real  m_lasts [2];
  logic m_ovf   [2];

  initial begin
    clk = 1'b0;
    #1;
    forever begin
      clk = 1'b1; #0.5;
      clk = 1'b0; #0.5;
    end
  end

  function automatic real rabs(input real x);
    return (x < 0.0) ? -x : x;
  endfunction

  task automatic model_edge(input int k, input real t_ns);
    logic pop;
    real  s, ss;
    if (rst) begin
      m_win[k].delete(); m_wins[k].delete();
      m_q[k].delete();   m_qs[k].delete();
      m_last[k] = 0.0; m_lasts[k] = 0.0; m_ovf[k] = 1'b0;
    end else begin
      pop = (m_q[k].size() > 0) && tb_rdy[k];
      if (pop) begin
        void'(m_q[k].pop_front());
        void'(m_qs[k].pop_front());
      end
      if (tb_en[k]) begin
        m_win[k].push_back(tb_in[k].a + tb_in[k].b * (t_ns * 1.0e-9 - tb_in[k].t0));
        m_wins[k].push_back(tb_in[k].b);
        if (m_win[k].size() == m_dec[k]) begin
          s = 0.0; ss = 0.0;
          foreach (m_win[k][i]) begin
            s  = s + m_win[k][i];
            ss = ss + m_wins[k][i];
          end
          if (m_q[k].size() < DEPTH) begin
            m_q[k].push_back(s / m_dec[k]);
            m_qs[k].push_back(ss / m_dec[k]);
          end else begin
            m_ovf[k] = 1'b1;
          end
          m_win[k].delete(); m_wins[k].delete();
        end
      end
      if (m_q[k].size() > 0) begin
        m_last[k]  = m_q[k][0];
        m_lasts[k] = m_qs[k][0];
      end
    end
  endtask

  task automatic check(input int k, input logic obs_v, input real obs_o,
                       input logic obs_ovf, input real obs_s);
    logic exp_v;
    exp_v = (m_q[k].size() > 0);
    n_tests++;
    assert (obs_v === exp_v) else begin
      n_fail++;
      $error("FAIL valid[%0d] t=%0t got %0b exp %0b", k, $realtime, obs_v, exp_v);
    end
    n_tests++;
    assert (rabs(obs_o - m_last[k]) <= TOL * (1.0 + rabs(m_last[k]))) else begin
      n_fail++;
      $error("FAIL out[%0d] t=%0t got %f exp %f", k, $realtime, obs_o, m_last[k]);
    end
    n_tests++;
    assert (obs_ovf === m_ovf[k]) else begin
      n_fail++;
      $error("FAIL ovf[%0d] t=%0t got %0b exp %0b", k, $realtime, obs_ovf, m_ovf[k]);
    end
`ifdef PWL2REAL_SLOPE_OUT_EN
    n_tests++;
    assert (rabs(obs_s - m_lasts[k]) <= 1.0e-3 * (1.0 + rabs(m_lasts[k]))) else begin
      n_fail++;
      $error("FAIL slope[%0d] t=%0t got %f exp %f", k, $realtime, obs_s, m_lasts[k]);
    end
`else
    if (obs_s != 0.0) $display("note: unexpected slope stub %f", obs_s);
`endif
  endtask

  task automatic tick();
    real t_ns;
    real s4, s1;
    @(posedge clk);
    t_ns = $realtime;
    model_edge(0, t_ns);
    model_edge(1, t_ns);
    #0.25;
`ifdef PWL2REAL_SLOPE_OUT_EN
    s4 = bus4.o_out_slope;
    s1 = bus1.o_out_slope;
`else
    s4 = 0.0;
    s1 = 0.0;
`endif
    check(0, bus4.o_out_valid, bus4.o_out, bus4.o_ovf, s4);
    check(1, bus1.o_out_valid, bus1.o_out, bus1.o_ovf, s1);
  endtask

  task automatic drive(input logic en, input logic rdy, input real a, input real b, input real t0);
    for (int k = 0; k < 2; k++) begin
      tb_en[k]  = en;
      tb_rdy[k] = rdy;
      tb_in[k].a  = a;
      tb_in[k].b  = b;
      tb_in[k].t0 = t0;
    end
  endtask

  initial begin
    m_dec[0] = 4;
    m_dec[1] = 1;
    rst = 1'b1;
    drive(1'b1, 1'b1, 0.0, 1.0e9, 0.0);

    // Reset state
    tick();
    rst = 1'b0;

    // Ramp: value equals time in ns
    repeat (9) tick();

    // Constant input
    drive(1'b1, 1'b1, 0.8, 0.0, 0.0);
    repeat (6) tick();

    // Back-pressure until overflow, then drain with sampling off
    drive(1'b1, 1'b0, 0.0, 1.0e9, 0.0);
    repeat (18) tick();
    drive(1'b0, 1'b1, 0.0, 1.0e9, 0.0);
    repeat (5) tick();

    // Full with pop on the push edge
    rst = 1'b1; tick(); rst = 1'b0;
    drive(1'b1, 1'b0, 0.0, 1.0e9, 0.0);
    repeat (4) tick();
    drive(1'b1, 1'b1, 0.0, 1.0e9, 0.0);
    repeat (6) tick();

    // Enable gap in the middle of a window
    rst = 1'b1; tick(); rst = 1'b0;
    drive(1'b1, 1'b1, 0.0, 1.0e9, 0.0);
    repeat (2) tick();
    drive(1'b0, 1'b1, 0.0, 1.0e9, 0.0);
    repeat (3) tick();
    drive(1'b1, 1'b1, 0.0, 1.0e9, 0.0);
    repeat (6) tick();

    // Reset mid-window with stored words
    drive(1'b1, 1'b0, 0.0, 1.0e9, 0.0);
    repeat (6) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    drive(1'b1, 1'b1, 0.0, 1.0e9, 0.0);
    repeat (5) tick();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < 2; k++) begin
        tb_en[k]    = ($urandom_range(3) != 0);
        tb_rdy[k]   = ($urandom_range(2) != 0);
        tb_in[k].a  = real'($urandom_range(2000)) / 1000.0 - 1.0;
        tb_in[k].b  = real'($urandom_range(200)) * 1.0e6 - 1.0e8;
        tb_in[k].t0 = $realtime * 1.0e-9 - real'($urandom_range(5)) * 1.0e-9;
      end
      rst = ($urandom_range(60) == 0);
      tick();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
